// File: rtl/tff_ctrl_pkg.sv
// Shared constants for the toggle-flip-flop counter sequencer:
// FSM state encodings and the per-cycle toggle-mode selector.
package tff_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } tmode_e;

endpackage

// File: rtl/tff_stage.sv
// One T flip-flop stage of the counter bank: q <= q ^ t, cleared by a
// synchronous active-high reset.
module tff_stage (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_r;

  // Toggle when t is set; synchronous clear on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 1'b0;
    end else begin
      q_r <= q_r ^ t;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer for a WIDTH-bit bank of T stages forming a programmable counter.
// Computes the per-stage toggle vector (hold/load/up/down) and runs the
// start/stop/done handshake. Optional feature: define TFF_CTRL_AUTORELOAD_EN
// to reload load_val on reaching terminal and keep running instead of
// passing through DONE.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic             done_nxt_s;
  tmode_e           mode_s;
  logic             at_term_s;
  logic [WIDTH-1:0] t_up_s;
  logic [WIDTH-1:0] t_dn_s;
  logic [WIDTH-1:0] tgl_s;

  assign at_term_s = (count == terminal);

  // Ripple-style toggle enables: a stage flips when all lower stages are
  // all-ones (counting up) or all-zeros (counting down).
  for (genvar i = 0; i < WIDTH; i++) begin : g_tvec
    if (i == 0) begin : g_lsb
      assign t_up_s[i] = 1'b1;
      assign t_dn_s[i] = 1'b1;
    end else begin : g_upper
      assign t_up_s[i] = &count[i-1:0];
      assign t_dn_s[i] = &(~count[i-1:0]);
    end
  end

  // Next-state, latched direction, done pulse and toggle mode selection.
  always_comb begin
    state_nxt_s = state_r;
    dir_nxt_s   = dir_r;
    done_nxt_s  = 1'b0;
    mode_s      = HOLD;
    case (state_r)
      IDLE: begin
        if (load) begin
          mode_s = LOAD;
        end else if (start) begin
          dir_nxt_s   = up;
          state_nxt_s = RUN;
        end else begin
          mode_s = HOLD;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt_s = IDLE;
        end else if (at_term_s) begin
          done_nxt_s = 1'b1;
`ifdef TFF_CTRL_AUTORELOAD_EN
          mode_s = LOAD;
`else
          state_nxt_s = DONE;
`endif
        end else begin
          mode_s = dir_r ? UP : DOWN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Translate the selected mode into the per-stage toggle vector.
  always_comb begin
    tgl_s = {WIDTH{1'b0}};
    case (mode_s)
      HOLD:    tgl_s = {WIDTH{1'b0}};
      LOAD:    tgl_s = count ^ load_val;
      UP:      tgl_s = t_up_s;
      DOWN:    tgl_s = t_dn_s;
      default: tgl_s = {WIDTH{1'b0}};
    endcase
  end

  // Control registers; busy/done are registered from the next state so
  // no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      dir_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      dir_r   <= dir_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= done_nxt_s;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tff_stage u_stage (
      .clk (clk),
      .rst (rst),
      .t   (tgl_s[i]),
      .q   (count[i])
    );
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule
